// File: rtl/vga_pkg.sv
// Shared VGA types: per-axis timing record, packed colour type and the 640x480@60 mode.
package vga_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_timing_t;

  localparam int DEF_COLOR_W = 2;

  typedef logic [3*DEF_COLOR_W-1:0] rgb_t;

  localparam vga_timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

endpackage

// File: rtl/vga_timing.sv
// VGA raster counters with registered sync and end-of-line/frame pulses; exposes the
// current raster position so the engine can register its pixel on the same cycle.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = int'(VGA_640X480_H.active),
  parameter int H_FP     = int'(VGA_640X480_H.fp),
  parameter int H_SYNC   = int'(VGA_640X480_H.sync),
  parameter int H_BP     = int'(VGA_640X480_H.bp),
  parameter int V_ACTIVE = int'(VGA_640X480_V.active),
  parameter int V_FP     = int'(VGA_640X480_V.fp),
  parameter int V_SYNC   = int'(VGA_640X480_V.sync),
  parameter int V_BP     = int'(VGA_640X480_V.bp),
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_in,
  output logic                        active_o,
  output logic [$clog2(H_ACTIVE)-1:0] x_o,
  output logic [$clog2(V_ACTIVE)-1:0] y_o,
  output logic                        frame_end_o,
  output logic                        hsync_o,
  output logic                        vsync_o,
  output logic                        next_vertical_o,
  output logic                        next_frame_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  int            h_i;
  int            v_i;
  logic          line_end;
  logic          hs_on;
  logic          vs_on;

  assign h_i = int'(h_cnt);
  assign v_i = int'(v_cnt);

  assign line_end    = (h_i == H_TOT - 1);
  assign frame_end_o = line_end && (v_i == V_TOT - 1);
  assign active_o    = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
  assign hs_on       = (h_i >= H_ACTIVE + H_FP) && (h_i < H_ACTIVE + H_FP + H_SYNC);
  assign vs_on       = (v_i >= V_ACTIVE + V_FP) && (v_i < V_ACTIVE + V_FP + V_SYNC);
  assign x_o         = h_cnt[$clog2(H_ACTIVE)-1:0];
  assign y_o         = v_cnt[$clog2(V_ACTIVE)-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      hsync_o         <= ~SYNC_POL;
      vsync_o         <= ~SYNC_POL;
      next_vertical_o <= 1'b0;
      next_frame_o    <= 1'b0;
    end else begin
      // Outputs describe the position the counters held this cycle, hence one clock behind.
      hsync_o         <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync_o         <= vs_on ? SYNC_POL : ~SYNC_POL;
      next_vertical_o <= line_end;
      next_frame_o    <= frame_end_o;
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_i == V_TOT - 1) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA timing plus one double-buffered 1-bpp sprite over a background colour.
// Optional VGA_SPRITE_BOUNCE_EN: sprite drifts diagonally and bounces off the active edges.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = int'(VGA_640X480_H.active),
  parameter int H_FP     = int'(VGA_640X480_H.fp),
  parameter int H_SYNC   = int'(VGA_640X480_H.sync),
  parameter int H_BP     = int'(VGA_640X480_H.bp),
  parameter int V_ACTIVE = int'(VGA_640X480_V.active),
  parameter int V_FP     = int'(VGA_640X480_V.fp),
  parameter int V_SYNC   = int'(VGA_640X480_V.sync),
  parameter int V_BP     = int'(VGA_640X480_V.bp),
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_in,
  input  logic                        bm_we_i,
  input  logic [$clog2(SPR_H)-1:0]    bm_row_i,
  input  logic [SPR_W-1:0]            bm_data_i,
  input  logic                        pos_we_i,
  input  logic [$clog2(H_ACTIVE)-1:0] pos_x_i,
  input  logic [$clog2(V_ACTIVE)-1:0] pos_y_i,
  input  logic [3*COLOR_W-1:0]        spr_color_i,
  input  logic [3*COLOR_W-1:0]        bg_color_i,
  output logic [3*COLOR_W-1:0]        rrggbb_o,
  output logic                        hsync_o,
  output logic                        vsync_o,
  output logic                        next_vertical_o,
  output logic                        next_frame_o
);

  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(V_ACTIVE);
  localparam int RW  = $clog2(SPR_H);
  localparam int CXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

  logic          active;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          frame_end;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk_i           (clk_i),
    .rst_in          (rst_in),
    .active_o        (active),
    .x_o             (x),
    .y_o             (y),
    .frame_end_o     (frame_end),
    .hsync_o         (hsync_o),
    .vsync_o         (vsync_o),
    .next_vertical_o (next_vertical_o),
    .next_frame_o    (next_frame_o)
  );

  logic [SPR_W-1:0] bitmap [SPR_H];
  logic [XW-1:0]    shadow_x, act_x, nxt_x;
  logic [YW-1:0]    shadow_y, act_y, nxt_y;

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      for (int i = 0; i < SPR_H; i++) bitmap[i] <= '0;
    end else if (bm_we_i) begin
      bitmap[bm_row_i] <= bm_data_i;
    end
  end

`ifdef VGA_SPRITE_BOUNCE_EN
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - SPR_W);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - SPR_H);

  // dir_* = 1 means the sprite is currently moving toward 0 on that axis.
  logic          dir_x, dir_y, pend;
  logic          neg_x, neg_y, nxt_dir_x, nxt_dir_y;
  logic [XW-1:0] mv_x;
  logic [YW-1:0] mv_y;

  always_comb begin
    neg_x = dir_x;
    if (act_x == '0)         neg_x = 1'b0;
    else if (act_x >= X_MAX) neg_x = 1'b1;
    neg_y = dir_y;
    if (act_y == '0)         neg_y = 1'b0;
    else if (act_y >= Y_MAX) neg_y = 1'b1;
    mv_x = neg_x ? act_x - XW'(1) : act_x + XW'(1);
    mv_y = neg_y ? act_y - YW'(1) : act_y + YW'(1);
    nxt_dir_x = neg_x;
    if (mv_x == X_MAX)   nxt_dir_x = 1'b1;
    else if (mv_x == '0) nxt_dir_x = 1'b0;
    nxt_dir_y = neg_y;
    if (mv_y == Y_MAX)   nxt_dir_y = 1'b1;
    else if (mv_y == '0) nxt_dir_y = 1'b0;
    nxt_x = pos_we_i ? pos_x_i : (pend ? shadow_x : mv_x);
    nxt_y = pos_we_i ? pos_y_i : (pend ? shadow_y : mv_y);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      dir_x <= 1'b0;
      dir_y <= 1'b0;
      pend  <= 1'b0;
    end else if (frame_end) begin
      pend <= 1'b0;
      if (!pos_we_i && !pend) begin
        dir_x <= nxt_dir_x;
        dir_y <= nxt_dir_y;
      end
    end else if (pos_we_i) begin
      pend <= 1'b1;
    end
  end
`else
  assign nxt_x = pos_we_i ? pos_x_i : shadow_x;
  assign nxt_y = pos_we_i ? pos_y_i : shadow_y;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      shadow_x <= '0;
      shadow_y <= '0;
      act_x    <= '0;
      act_y    <= '0;
    end else begin
      if (pos_we_i) begin
        shadow_x <= pos_x_i;
        shadow_y <= pos_y_i;
      end
      if (frame_end) begin
        act_x <= nxt_x;
        act_y <= nxt_y;
      end
    end
  end

  // One extra bit keeps x-pos_x from aliasing into the box when x < pos_x.
  logic [XW:0]      dx;
  logic [YW:0]      dy;
  logic             in_box;
  logic [SPR_W-1:0] row_bits;
  logic             spr_hit;

  assign dx       = {1'b0, x} - {1'b0, act_x};
  assign dy       = {1'b0, y} - {1'b0, act_y};
  assign in_box   = (x >= act_x) && (y >= act_y) &&
                    (dx < (XW+1)'(SPR_W)) && (dy < (YW+1)'(SPR_H));
  assign row_bits = bitmap[dy[RW-1:0]];
  assign spr_hit  = in_box && row_bits[dx[CXW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_in)      rrggbb_o <= '0;
    else if (!active) rrggbb_o <= '0;
    else              rrggbb_o <= spr_hit ? spr_color_i : bg_color_i;
  end

endmodule
